game_display: RTL and testbench
===============================

Name: game_display

Overview:
- Receives 8N1 serial bytes on a UART line and shows the two most recent good bytes as four hex digits on seven-segment displays.
- Also mirrors the latest good byte on LEDs and reports framing errors.
- Top-level board block for the game status display; one clock domain, CLOCK_50.

Parameters:
- CLK_HZ, 50000000, input clock frequency in Hz.
- BAUD, 57600, serial bit rate.
- CLKS_PER_BIT (localparam), CLK_HZ/BAUD = 868, clocks per bit period; HALF_BIT = 434.

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- rst_n  in  1  reset; synchronous, active-high (asserted when 1), despite the name.
- uart_rx_i  in  1  asynchronous serial input, idles high.
- HEX0  out  7  digit 0, low nibble of newest byte; active-low segments, bit0=a … bit6=g.
- HEX1  out  7  digit 1, high nibble of newest byte.
- HEX2  out  7  digit 2, low nibble of previous byte.
- HEX3  out  7  digit 3, high nibble of previous byte.
- LEDR  out  8  newest good byte.
- rx_valid_o  out  1  one-cycle pulse per accepted byte.
- frame_err_o  out  1  sticky framing-error flag.

Behaviour:
- Reset values:
  - HEX0–HEX3 = 7'h7F (blank).
  - LEDR = 0, rx_valid_o = 0, frame_err_o = 0.
  - Synchronizer flops = 1.
  - FSM = IDLE; counters = 0.
- Reset asserted mid-frame aborts the frame; no partial byte is kept.
- Input sync: uart_rx_i passes through a 2-flop synchronizer. All decisions use the synchronized bit.
- FSM states and transitions:
  - IDLE: on a synchronized low, go to START and clear the counter.
  - START: at count HALF_BIT-1, sample the line.
    - Low: go to DATA with bit index 0.
    - High: glitch, return to IDLE.
  - DATA: every CLKS_PER_BIT clocks (mid-bit), sample into the shift register, LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample the line.
    - High: byte accepted; go to IDLE.
    - Low: framing error. Set frame_err_o, discard the byte, go to BREAK.
  - BREAK: wait for the synchronized line to be high, then go to IDLE.
- On an accepted byte B, in one registered update (same cycle as rx_valid_o = 1):
  - HEX3/HEX2 ← previous HEX1/HEX0.
  - HEX1 ← seg(B[7:4]); HEX0 ← seg(B[3:0]).
  - LEDR ← B.
- rx_valid_o is high for exactly one clock per good byte and never on a framing error.
- frame_err_o clears only on reset.
- seg() table, active-low:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Baud tolerance: sampling at mid-bit tolerates ±4% rate mismatch.
- Back-to-back frames: a start edge may be detected one clock after STOP exits to IDLE.

Decomposition:
- Package game_display_pkg holds:
  - CLK_HZ/BAUD-derived constants.
  - The rx state enum (IDLE, START, DATA, STOP, BREAK).
  - The seg7 nibble-to-segment function.
- One sub-module, uart_rx. It contains the synchronizer, FSM and shift register, and outputs data[7:0], valid and frame_err.
- The top level keeps the display shift registers and LEDR.

Test Plan:
- Reset check: hold rst_n=1 for 10 µs, then release. Then HEX0–3 = 7F, LEDR = 00, rx_valid_o = 0 and frame_err_o = 0.
- Framing error: line idle, then start bit, data bits 1,0,1,0,1,0,1,0 (LSB first, 0x55), then stop bit 0, at 17.36 µs/bit. Then frame_err_o = 1, no rx_valid_o pulse, HEX stay 7F, LEDR = 00. The line returning high re-arms IDLE.
- Good byte: 0x55 with stop bit 1. Then one rx_valid_o pulse about 9.5 bit times after the start edge, LEDR = 55, HEX1 = HEX0 = 12, HEX3 = HEX2 = 7F.
- Second byte: 0xA3 after 0x55. Then HEX3 = HEX2 = 12, HEX1 = 08, HEX0 = 30, LEDR = A3.
- Start glitch: line low for 5 µs (< half bit), then high. Then no reception and the FSM is back in IDLE.
- Reset mid-frame: assert rst_n during DATA bit 4 of 0xFF. Then all outputs return to reset values. The next good byte 0x0C gives HEX1 = 40, HEX0 = 46, HEX3/HEX2 = 7F.

Source files
------------

// File: rtl/game_display_pkg.sv
// game_display_pkg: shared UART timing defaults, receiver states and the hex-to-segment table.
package game_display_pkg;
  localparam int DEF_CLK_HZ = 50_000_000;
  localparam int DEF_BAUD = 57_600;
  localparam int CNT_W = 16;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;
  localparam logic [6:0] SEG_TBL [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  function automatic logic [6:0] seg7(input logic [3:0] n);
    return SEG_TBL[n];
  endfunction
endpackage

// File: rtl/game_display_if.sv
// game_display_if: received-byte bundle from the UART receiver to the display logic.
interface game_display_if;
  logic [7:0] data;
  logic valid;
  logic frame_err;
  modport master (output data, valid, frame_err);
  modport slave (input data, valid, frame_err);
endinterface

// File: rtl/game_display_uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchronizer, mid-bit sampling and sticky framing error.
module uart_rx
  import game_display_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEF_CLK_HZ / DEF_BAUD
) (
  input  logic clk,
  input  logic rst,
  input  logic rx_i,
  game_display_if.master rx_o
);
  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);
  logic [1:0] sync_q;
  rx_state_e state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0] idx_q;
  logic [7:0] shift_q, data_q;
  logic valid_q, ferr_q;
  logic rx;
  assign rx = sync_q[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      state_q <= IDLE;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '0;
      data_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], rx_i};
      valid_q <= 1'b0;
      case (state_q)
        IDLE: if (!rx) begin
          state_q <= START;
          cnt_q <= '0;
        end
        START: if (cnt_q == HALF_END) begin
          state_q <= rx ? IDLE : DATA;
          cnt_q <= '0;
          idx_q <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        DATA: if (cnt_q == BIT_END) begin
          shift_q <= {rx, shift_q[7:1]};
          cnt_q <= '0;
          idx_q <= idx_q + 1'b1;
          if (idx_q == 3'd7) state_q <= STOP;
        end else cnt_q <= cnt_q + 1'b1;
        STOP: if (cnt_q == BIT_END) begin
          cnt_q <= '0;
          state_q <= rx ? IDLE : BREAK;
          valid_q <= rx;
          ferr_q <= ferr_q | !rx;
          if (rx) data_q <= shift_q;
        end else cnt_q <= cnt_q + 1'b1;
        BREAK: if (rx) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign rx_o.data = data_q;
  assign rx_o.valid = valid_q;
  assign rx_o.frame_err = ferr_q;
endmodule

// File: rtl/game_display.sv
// game_display: shows the two newest good UART bytes as four hex digits and the newest on LEDR.
module game_display
  import game_display_pkg::*;
#(
  parameter int CLK_HZ = DEF_CLK_HZ,
  parameter int BAUD = DEF_BAUD
) (
  input  logic CLOCK_50,
  input  logic rst_n,
  input  logic uart_rx_i,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [6:0] HEX3,
  output logic [7:0] LEDR,
  output logic rx_valid_o,
  output logic frame_err_o
);
  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  game_display_if rx_if ();
  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk (CLOCK_50),
    .rst (rst_n),
    .rx_i(uart_rx_i),
    .rx_o(rx_if.master)
  );
  logic [3:0][6:0] hex_q;
  logic [7:0] led_q;
  logic valid_q;
  // rx_valid_o is re-registered so it lines up with the display update
  always_ff @(posedge CLOCK_50) begin
    if (rst_n) begin
      hex_q <= {4{7'h7F}};
      led_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= rx_if.valid;
      if (rx_if.valid) begin
        hex_q <= {hex_q[1], hex_q[0], seg7(rx_if.data[7:4]), seg7(rx_if.data[3:0])};
        led_q <= rx_if.data;
      end
    end
  end
  assign {HEX3, HEX2, HEX1, HEX0} = hex_q;
  assign LEDR = led_q;
  assign rx_valid_o = valid_q;
  assign frame_err_o = rx_if.frame_err;
endmodule

// File: tb/tb_game_display.sv
// tb_game_display: directed UART frames at 57600 baud against hand-computed display values.
module tb_game_display;
  import game_display_pkg::*;
  localparam realtime BIT_T = 17360ns;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1;
  logic [6:0] h0, h1, h2, h3;
  logic [7:0] led;
  logic vld, ferr;
  int errors = 0, checks = 0, vcnt = 0;
  realtime vt = 0, t0 = 0;
  always #10ns clk = ~clk;
  game_display dut (
    .CLOCK_50(clk), .rst_n(rst), .uart_rx_i(rx),
    .HEX0(h0), .HEX1(h1), .HEX2(h2), .HEX3(h3),
    .LEDR(led), .rx_valid_o(vld), .frame_err_o(ferr)
  );
  always @(posedge clk) if (vld) begin
    vcnt <= vcnt + 1;
    vt <= $realtime;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic disp(input string tag, input logic [6:0] e3, e2, e1, e0, input logic [7:0] el);
    chk({tag, " HEX3"}, 32'(h3), 32'(e3));
    chk({tag, " HEX2"}, 32'(h2), 32'(e2));
    chk({tag, " HEX1"}, 32'(h1), 32'(e1));
    chk({tag, " HEX0"}, 32'(h0), 32'(e0));
    chk({tag, " LEDR"}, 32'(led), 32'(el));
  endtask
  task automatic send(input logic [7:0] b, input logic stop);
    t0 = $realtime;
    rx = 1'b0;
    #BIT_T;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #BIT_T;
    end
    rx = stop;
    #BIT_T;
    rx = 1'b1;
    #BIT_T;
  endtask
  initial begin
    #10us;
    @(negedge clk) rst = 1'b0;
    @(negedge clk);
    disp("reset", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 8'h00);
    chk("reset valid", 32'(vld), 32'd0);
    chk("reset ferr", 32'(ferr), 32'd0);
    #(3 * BIT_T);
    send(8'h55, 1'b0);
    chk("ferr set", 32'(ferr), 32'd1);
    chk("ferr no pulse", 32'(vcnt), 32'd0);
    disp("ferr", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 8'h00);
    chk("ferr rearm", 32'(dut.u_rx.state_q), 32'(IDLE));
    send(8'h55, 1'b1);
    chk("0x55 pulses", 32'(vcnt), 32'd1);
    chk("0x55 timing", 32'((vt - t0) > 163.9us && (vt - t0) < 165.9us), 32'd1);
    disp("0x55", 7'h7F, 7'h7F, 7'h12, 7'h12, 8'h55);
    chk("ferr sticky", 32'(ferr), 32'd1);
    send(8'hA3, 1'b1);
    chk("0xA3 pulses", 32'(vcnt), 32'd2);
    disp("0xA3", 7'h12, 7'h12, 7'h08, 7'h30, 8'hA3);
    rx = 1'b0;
    #5us;
    rx = 1'b1;
    #BIT_T;
    chk("glitch idle", 32'(dut.u_rx.state_q), 32'(IDLE));
    chk("glitch pulses", 32'(vcnt), 32'd2);
    chk("glitch LEDR", 32'(led), 32'hA3);
    rx = 1'b0;
    #BIT_T;
    rx = 1'b1;
    #(4.5 * BIT_T);
    @(negedge clk) rst = 1'b1;
    repeat (3) @(negedge clk);
    disp("midrst", 7'h7F, 7'h7F, 7'h7F, 7'h7F, 8'h00);
    chk("midrst ferr", 32'(ferr), 32'd0);
    chk("midrst valid", 32'(vld), 32'd0);
    @(negedge clk) rst = 1'b0;
    #(5 * BIT_T);
    chk("midrst idle", 32'(dut.u_rx.state_q), 32'(IDLE));
    chk("midrst pulses", 32'(vcnt), 32'd2);
    send(8'h0C, 1'b1);
    chk("0x0C pulses", 32'(vcnt), 32'd3);
    disp("0x0C", 7'h7F, 7'h7F, 7'h40, 7'h46, 8'h0C);
    chk("0x0C ferr", 32'(ferr), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
